// File: rtl/fmap_flatten_buffer_if.sv
// Column-capture and flattened-stream bus of fmap_flatten_buffer.
// slave = the buffer itself, master = the conv/pool producer plus FC consumer.
interface fmap_flatten_buffer_if #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_CHANNELS = 8,
   parameter int COL_SIZE     = 5,
   parameter int NUM_COLS     = 5,
   parameter int IDX_W        = $clog2(NUM_CHANNELS * NUM_COLS * COL_SIZE)
);
   logic                                                  valid_in;
   logic [NUM_CHANNELS-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0] input_columns;
   logic [DATA_WIDTH-1:0]                                 out_data;
   logic                                                  out_valid;
   logic                                                  out_ready;
   logic                                                  out_last;
   logic [IDX_W-1:0]                                      out_index;
   logic                                                  state_dbg;

   // An element transfers on a clock edge where out_valid && out_ready. Once
   // out_valid rises, out_data/out_index/out_last hold until that edge, and
   // out_valid never drops without a transfer. valid_in has no back-pressure:
   // a column arriving while its target bank is full is dropped.
   modport slave (
      input  valid_in, input_columns, out_ready,
      output out_data, out_valid, out_last, out_index, state_dbg
   );

   modport master (
      output valid_in, input_columns, out_ready,
      input  out_data, out_valid, out_last, out_index, state_dbg
   );
endinterface

// File: rtl/fmap_flatten_buffer.sv
// Collects pooled feature-map columns and streams the map channel-major to the FC stage.
// FMAP_FLATTEN_DOUBLE_BUF_EN defined: two banks (capture overlaps streaming); undefined: one bank.
module fmap_flatten_buffer #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_CHANNELS = 8,
   parameter int COL_SIZE     = 5,
   parameter int NUM_COLS     = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   fmap_flatten_buffer_if.slave  bus,
   output logic                  overflow,
   output logic                  busy
);
   localparam int TOTAL = NUM_CHANNELS * NUM_COLS * COL_SIZE;
   localparam int IDX_W = $clog2(TOTAL);
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int ROW_W = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;

`ifdef FMAP_FLATTEN_DOUBLE_BUF_EN
   localparam int   NB          = 2;
   localparam logic BANK_TOGGLE = 1'b1;
`else
   localparam int   NB          = 1;
   localparam logic BANK_TOGGLE = 1'b0;
`endif

   localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUM_CHANNELS - 1);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(COL_SIZE - 1);
   localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
   localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   logic [DATA_WIDTH-1:0] mem [NB][NUM_CHANNELS][NUM_COLS][COL_SIZE];

   logic [1:0]       full;
   logic             wr_bank;
   logic [COL_W-1:0] wr_col;
   logic             accept;
   logic             release_bank;

   state_t           state, state_nx;
   logic             rd_bank, rd_bank_nx;
   logic [CH_W-1:0]  ch, ch_nx;
   logic [COL_W-1:0] col, col_nx;
   logic [ROW_W-1:0] row, row_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic             at_last;

   assign accept = bus.valid_in && !full[wr_bank];

   // Storage carries no reset: the full flags alone decide what is readable.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            for (int r = 0; r < COL_SIZE; r++) begin
               mem[wr_bank][k][wr_col][r] <= bus.input_columns[k][r];
            end
         end
      end
   end

   // Drop decision uses full[] as registered, even if the reader frees it this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         full     <= '0;
         wr_bank  <= 1'b0;
         wr_col   <= '0;
         overflow <= 1'b0;
      end else begin
         if (bus.valid_in) begin
            if (!full[wr_bank]) begin
               if (wr_col == COL_MAX) begin
                  full[wr_bank] <= 1'b1;
                  wr_bank       <= wr_bank ^ BANK_TOGGLE;
                  wr_col        <= '0;
               end else begin
                  wr_col <= wr_col + COL_ONE;
               end
            end else begin
               overflow <= 1'b1;
            end
         end
         if (release_bank) full[rd_bank] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         rd_bank <= 1'b0;
         ch      <= '0;
         col     <= '0;
         row     <= '0;
         idx     <= '0;
      end else begin
         state   <= state_nx;
         rd_bank <= rd_bank_nx;
         ch      <= ch_nx;
         col     <= col_nx;
         row     <= row_nx;
         idx     <= idx_nx;
      end
   end

   assign at_last = (ch == CH_MAX) && (col == COL_MAX) && (row == ROW_MAX);

   always_comb begin
      state_nx      = state;
      rd_bank_nx    = rd_bank;
      ch_nx         = ch;
      col_nx        = col;
      row_nx        = row;
      idx_nx        = idx;
      release_bank  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_last  = 1'b0;
      case (state)
         S_IDLE: begin
            if (full[rd_bank]) begin
               state_nx = S_STREAM;
               ch_nx    = '0;
               col_nx   = '0;
               row_nx   = '0;
               idx_nx   = '0;
            end
         end
         S_STREAM: begin
            bus.out_valid = 1'b1;
            bus.out_last  = at_last;
            if (bus.out_ready) begin
               if (at_last) begin
                  // Returning to IDLE costs one bubble before the next map.
                  release_bank = 1'b1;
                  rd_bank_nx   = rd_bank ^ BANK_TOGGLE;
                  state_nx     = S_IDLE;
                  ch_nx        = '0;
                  col_nx       = '0;
                  row_nx       = '0;
                  idx_nx       = '0;
               end else begin
                  idx_nx = idx + IDX_ONE;
                  if (row == ROW_MAX) begin
                     row_nx = '0;
                     if (col == COL_MAX) begin
                        col_nx = '0;
                        ch_nx  = ch + CH_ONE;
                     end else begin
                        col_nx = col + COL_ONE;
                     end
                  end else begin
                     row_nx = row + ROW_ONE;
                  end
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.out_data  = (state == S_STREAM) ? mem[rd_bank][ch][col][row] : '0;
   assign bus.out_index = idx;
   assign bus.state_dbg = (state == S_STREAM);
   assign busy          = (|full) || (wr_col != '0);
endmodule

// File: tb/tb_fmap_flatten_buffer.sv
// Scoreboard bench for fmap_flatten_buffer: directed maps, expected words queued, negedge monitor.
module tb_fmap_flatten_buffer;
   localparam int DW    = 16;
   localparam int NCH   = 8;
   localparam int CS    = 5;
   localparam int NC    = 5;
   localparam int TOTAL = NCH * NC * CS;
   localparam int IW    = 8;
   localparam int W     = 1 + IW + DW;
`ifdef FMAP_FLATTEN_DOUBLE_BUF_EN
   localparam bit DOUBLE = 1'b1;
`else
   localparam bit DOUBLE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic overflow;
   logic busy;

   always #5 clk = ~clk;

   fmap_flatten_buffer_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .COL_SIZE(CS),
                            .NUM_COLS(NC), .IDX_W(IW)) bus ();

   fmap_flatten_buffer #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH), .COL_SIZE(CS),
                         .NUM_COLS(NC)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .overflow (overflow),
      .busy     (busy)
   );

   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           failures = 0;
   int           lasts_seen = 0;
   bit           expect_bubble = 1'b0;
   bit           hold_v = 1'b0;
   logic [W-1:0] hold_word;
   logic [W-1:0] mon_word;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Element i of map 'tag': channel k=i/25, column c, row r -> {k,c,tag,r}.
   function automatic logic [W-1:0] exp_word(input int tag, input int i);
      int k = i / (NC * CS);
      int c = (i / CS) % NC;
      int r = i % CS;
      logic [DW-1:0] d;
      d = {k[3:0], c[3:0], tag[3:0], r[3:0]};
      return {(i == TOTAL - 1), IW'(i), d};
   endfunction

   task automatic push_map(input int tag);
      for (int i = 0; i < TOTAL; i++) exp_q.push_back(exp_word(tag, i));
   endtask

   task automatic drive_col(input int tag, input int c);
      for (int k = 0; k < NCH; k++) begin
         for (int r = 0; r < CS; r++) begin
            bus.input_columns[k][r] = {k[3:0], c[3:0], tag[3:0], r[3:0]};
         end
      end
      bus.valid_in = 1'b1;
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
   endtask

   task automatic send_map(input int tag, input bit stored);
      for (int c = 0; c < NC; c++) drive_col(tag, c);
      if (stored) push_map(tag);
   endtask

   task automatic drain(input bit rand_rdy, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         bus.out_ready = rand_rdy ? ($urandom_range(0, 99) >= 40) : 1'b1;
         @(posedge clk); #1;
         n++;
      end
      bus.out_ready = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout actual_left=%0d required_left=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_lasts(input int target, input int budget);
      int n = 0;
      while (lasts_seen < target && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_last", lasts_seen, target);
   endtask

   // Monitor: compares every accepted element, stall stability and the inter-map bubble.
   always @(negedge clk) begin
      if (rst) begin
         hold_v        = 1'b0;
         expect_bubble = 1'b0;
      end else begin
         if (expect_bubble) begin
            check("bubble", bus.out_valid, 0);
            expect_bubble = 1'b0;
         end
         if (bus.out_valid) begin
            mon_word = {bus.out_last, bus.out_index, bus.out_data};
            if (hold_v) check("stall_stable", mon_word, hold_word);
            if (bus.out_ready) begin
               hold_v = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_out actual=%0h required=none", mon_word);
               end else begin
                  check("stream_word", mon_word, exp_q.pop_front());
               end
               if (bus.out_last) begin
                  lasts_seen++;
                  expect_bubble = 1'b1;
               end
            end else begin
               hold_v    = 1'b1;
               hold_word = mon_word;
            end
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n_valid;
      int n;
      rst               = 1'b1;
      bus.valid_in      = 1'b0;
      bus.input_columns = '0;
      bus.out_ready     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_index", bus.out_index, 0);
      check("rst_overflow", overflow, 0);
      check("rst_busy", busy, 0);

      // Single map, ready always high; valid appears one edge after the 5th column.
      for (int c = 0; c < NC; c++) drive_col(0, c);
      push_map(0);
      check("latency_pre", bus.out_valid, 0);
      @(posedge clk); #1;
      check("latency_valid", bus.out_valid, 1);
      check("first_index", bus.out_index, 0);
      drain(1'b0, 400);
      check("t1_overflow", overflow, 0);

      // Same map shape with random back-pressure.
      bus.out_ready = 1'b0;
      send_map(1, 1'b1);
      drain(1'b1, 2000);

      // Stalled reader: map A streams stalled, map B fills the other bank, 11th column dropped.
      bus.out_ready = 1'b0;
      send_map(2, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      send_map(3, DOUBLE);
      check("t3_busy", busy, 1);
      check("t3_overflow_pre", overflow, DOUBLE ? 0 : 1);
      drive_col(9, 0);
      check("t3_overflow", overflow, 1);
      check("t3_stalled_valid", bus.out_valid, 1);
      check("t3_stalled_index", bus.out_index, 0);
      drain(1'b0, 1000);

      // Reset in the middle of a stream.
      send_map(4, 1'b1);
      n = 0;
      while (!(bus.out_valid && bus.out_index == IW'(57)) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("t4_reach_57", bus.out_index, 57);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check("t4_out_valid", bus.out_valid, 0);
      check("t4_overflow", overflow, 0);
      check("t4_busy", busy, 0);
      send_map(5, 1'b1);
      drain(1'b0, 400);

      // Three maps: two back to back, the third once the first has left.
      base = lasts_seen;
      bus.out_ready = 1'b1;
      send_map(6, 1'b1);
      send_map(7, DOUBLE);
      wait_lasts(base + 1, 400);
      send_map(8, 1'b1);
      drain(1'b0, 1000);
      check("t5_overflow", overflow, DOUBLE ? 0 : 1);
      check("t5_maps", lasts_seen, base + (DOUBLE ? 3 : 2));

      // Partial map stays parked until completed.
      for (int c = 0; c < 3; c++) drive_col(10, c);
      n_valid = 0;
      repeat (50) begin
         @(posedge clk); #1;
         if (bus.out_valid) n_valid++;
      end
      check("t6_no_valid", n_valid, 0);
      check("t6_busy", busy, 1);
      drive_col(10, 3);
      drive_col(10, 4);
      push_map(10);
      drain(1'b0, 400);
      repeat (3) @(posedge clk);
      #1;
      check("t6_busy_end", busy, 0);
      check("t6_valid_end", bus.out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
